// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: state encoding,
// word/byte constants and the byte-enable merge used at the commit point.
package dmem_responder_pkg;

   localparam int WORD_W   = 32;
   localparam int BYTE_CNT = WORD_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } stateT;

   function automatic logic [WORD_W-1:0] byteMerge(
      input logic [WORD_W-1:0]   oldWord,
      input logic [WORD_W-1:0]   newWord,
      input logic [BYTE_CNT-1:0] be
   );
      logic [WORD_W-1:0] merged;
      merged = oldWord;
      for (int i = 0; i < BYTE_CNT; i++) begin
         if (be[i]) merged[8*i +: 8] = newWord[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// DEPTH x 32 storage with one byte-enabled synchronous write port and one
// registered, write-first read port; out-of-range accesses read back zero.
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W = 7,
   parameter int DEPTH  = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                hit,
   input  logic                we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [WORD_W-1:0]   wdata,
   input  logic [BYTE_CNT-1:0] be,
   output logic [WORD_W-1:0]   rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en && hit && we && (|be)) begin
         mem[addr] <= byteMerge(mem[addr], wdata, be);
      end
   end

   // A store returns the merged word, so the read register sees the write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= '0;
      end else if (en) begin
         if (!hit)    rdata <= '0;
         else if (we) rdata <= byteMerge(mem[addr], wdata, be);
         else         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data-memory slave with valid/ready request and response
// channels and a fixed, configurable access latency.
//
// state | meaning
// IDLE  | ready for a request; accept captures it and starts the latency count
// WAIT  | counting down; the edge leaving WAIT with cnt==1 is the commit point
// RESP  | response presented and held until resp_ready
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 128,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [3:0]        req_be,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam bit ONE_CYCLE = (LATENCY == 1);
   localparam int CNT_W     = (LATENCY < 2) ? 1 : $clog2(LATENCY);
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

   stateT stateQ, stateD;
   logic [CNT_W-1:0]    cntQ;
   logic                weQ;
   logic [ADDR_W-1:0]   addrQ;
   logic [WORD_W-1:0]   wdataQ;
   logic [BYTE_CNT-1:0] beQ;
   logic                errQ;
   logic                accept, commit, hit;
   logic                selWe;
   logic [ADDR_W-1:0]   selAddr;
   logic [WORD_W-1:0]   selWdata;
   logic [BYTE_CNT-1:0] selBe;

   assign accept = req_valid && req_ready;

   // With single-cycle latency the accept edge is also the commit edge.
   assign selWe    = ONE_CYCLE ? req_we    : weQ;
   assign selAddr  = ONE_CYCLE ? req_addr  : addrQ;
   assign selWdata = ONE_CYCLE ? req_wdata : wdataQ;
   assign selBe    = ONE_CYCLE ? req_be    : beQ;
   assign hit      = {1'b0, selAddr} < DEPTH_LIM;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stateQ <= IDLE;
      else      stateQ <= stateD;
   end

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE:    if (accept) stateD = ONE_CYCLE ? RESP : WAIT;
         WAIT:    if (cntQ == CNT_W'(1)) stateD = RESP;
         RESP:    if (resp_ready) stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (stateQ == IDLE) && rst;
      resp_valid = (stateQ == RESP);
      commit     = ONE_CYCLE ? accept : ((stateQ == WAIT) && (cntQ == CNT_W'(1)));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cntQ   <= '0;
         weQ    <= 1'b0;
         addrQ  <= '0;
         wdataQ <= '0;
         beQ    <= '0;
         errQ   <= 1'b0;
      end else begin
         if (accept) begin
            cntQ   <= CNT_W'(LATENCY - 1);
            weQ    <= req_we;
            addrQ  <= req_addr;
            wdataQ <= req_wdata;
            beQ    <= req_be;
         end else if (stateQ == WAIT) begin
            cntQ <= cntQ - CNT_W'(1);
         end
         if (commit) errQ <= !hit;
      end
   end

   assign resp_err = errQ;

   dmem_array #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) uArray (
      .clk   (clk),
      .rst   (rst),
      .en    (commit),
      .hit   (hit),
      .we    (selWe),
      .addr  (selAddr),
      .wdata (selWdata),
      .be    (selBe),
      .rdata (resp_rdata)
   );

endmodule
